// File: rtl/inst_sram_responder_if.sv
// Instruction-SRAM request/response bundle between the fetch stage (master) and the SRAM responder (slave).
interface inst_sram_responder_if;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;

    modport master (output en, output wen, output addr, output wdata, input rdata, input err);
    modport slave  (input en, input wen, input addr, input wdata, output rdata, output err);
endinterface

// File: rtl/inst_sram_responder.sv
// Word-organised instruction SRAM with post-reset clear engine; optional counters under INST_SRAM_STAT_EN.
// Latency: read data and err one cycle after an accepted request; clear takes DEPTH cycles after reset.
// Backpressure: none; one request per cycle, requests are dropped while init_done is low.
module inst_sram_responder #(
    parameter int          ADDR_W         = 10,
    parameter logic [31:0] BASE_ADDR      = 32'h1c00_0000,
    parameter logic [31:0] CLR_VALUE      = 32'h0000_0000,
    parameter logic [31:0] OOR_VALUE      = 32'h0340_0000,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    inst_sram_responder_if.slave  inst_sram,
    output logic                  init_done
`ifdef INST_SRAM_STAT_EN
    ,
    output logic [31:0]           rd_cnt,
    output logic [31:0]           wr_cnt,
    output logic [15:0]           oor_cnt
`endif
);
    localparam int          DEPTH       = 1 << ADDR_W;
    localparam logic [31:0] RANGE_BYTES = 32'(4 * DEPTH);
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {ST_CLEAR, ST_READY} state_t;
    localparam state_t ST_RESET = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   ptr, ptr_nxt;
    logic                clr_we;
    logic [31:0]         mem [DEPTH];

    logic [31:0]         off;
    logic                in_range;
    logic [ADDR_W-1:0]   idx;
    logic                accept;
    logic                rd_hit, wr_hit, oor_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_RESET;
            ptr       <= '0;
            init_done <= !CLEAR_ON_RESET;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            init_done <= (state_nxt == ST_READY);
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        clr_we    = 1'b0;
        case (state)
            ST_CLEAR: begin
                clr_we  = 1'b1;
                ptr_nxt = ptr + ADDR_W'(1);
                if (ptr == PTR_LAST)
                    state_nxt = ST_READY;
            end
            ST_READY: state_nxt = ST_READY;
            default:  state_nxt = ST_READY;
        endcase
    end

    // Modular subtract: addresses below the base wrap to a huge offset and fall out of range.
    always_comb begin
        off      = inst_sram.addr - BASE_ADDR;
        in_range = (off < RANGE_BYTES);
        idx      = off[ADDR_W+1:2];
        accept   = (state == ST_READY) && inst_sram.en;
        rd_hit   = accept && in_range && (inst_sram.wen == 4'b0000);
        wr_hit   = accept && in_range && (inst_sram.wen != 4'b0000);
        oor_hit  = accept && !in_range;
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[ptr] <= CLR_VALUE;
        end else if (wr_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (inst_sram.wen[b])
                    mem[idx][8*b +: 8] <= inst_sram.wdata[8*b +: 8];
            end
        end
    end

    // Read-first: the array read sees the value before any same-edge byte write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inst_sram.rdata <= '0;
            inst_sram.err   <= 1'b0;
        end else if (state != ST_READY) begin
            inst_sram.rdata <= '0;
            inst_sram.err   <= 1'b0;
        end else if (accept) begin
            inst_sram.rdata <= in_range ? mem[idx] : OOR_VALUE;
            inst_sram.err   <= !in_range;
        end else begin
            inst_sram.err   <= 1'b0;
        end
    end

`ifdef INST_SRAM_STAT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            oor_cnt <= '0;
        end else begin
            if (rd_hit)
                rd_cnt <= rd_cnt + 32'd1;
            if (wr_hit)
                wr_cnt <= wr_cnt + 32'd1;
            if (oor_hit && (oor_cnt != 16'hffff))
                oor_cnt <= oor_cnt + 16'd1;
        end
    end
`endif
endmodule
